// File: rtl/score_tracker.sv
// Egg-catching game score tracker: IDLE/PLAY/OVER FSM, combo-weighted scoring, lives.
// Define SCORE_TRACKER_HIGH_SCORE_EN to build the best-completed-game register.
module score_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_game,
  input  logic        egg_caught,
  input  logic        egg_missed,
  output logic [13:0] score,
  output logic        new_score,
  output logic [1:0]  lives,
  output logic        playing,
  output logic        game_over,
  output logic [13:0] high_score
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [14:0] SCORE_MAX = 15'd9999;

  state_t      state, state_nxt;
  logic [3:0]  combo, combo_nxt;
  logic [13:0] score_nxt;
  logic [1:0]  lives_nxt;
  logic        new_score_nxt;
  logic [2:0]  points;
  logic [14:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score     <= '0;
      lives     <= '0;
      combo     <= '0;
      new_score <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      combo     <= combo_nxt;
      new_score <= new_score_nxt;
      playing   <= (state_nxt == PLAY);
      game_over <= (state_nxt == OVER);
    end
  end

  // A catch on the same edge as a miss is scored with the pre-clear combo.
  always_comb begin
    points        = 3'd1 + {1'b0, combo[3:2]};
    sum           = {1'b0, score} + {12'd0, points};
    state_nxt     = state;
    score_nxt     = score;
    lives_nxt     = lives;
    combo_nxt     = combo;
    new_score_nxt = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_game) begin
          state_nxt     = PLAY;
          score_nxt     = '0;
          lives_nxt     = 2'd3;
          combo_nxt     = '0;
          new_score_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (egg_caught) begin
          score_nxt     = (sum > SCORE_MAX) ? SCORE_MAX[13:0] : sum[13:0];
          new_score_nxt = (score_nxt != score);
          combo_nxt     = (combo == 4'd15) ? combo : combo + 4'd1;
        end
        if (egg_missed) begin
          combo_nxt = '0;
          lives_nxt = lives - 2'd1;
          if (lives == 2'd1) state_nxt = OVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  logic [13:0] best;

  // Captures the final score of the game on the edge that ends it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      best <= '0;
    else if (state == PLAY && state_nxt == OVER && score_nxt > best)
      best <= score_nxt;
  end

  assign high_score = best;
`else
  assign high_score = '0;
`endif

endmodule
